object_transition: RTL and testbench

- Per-object 2D position integrator for the sprite and mouse-object layer.
- Each rising edge of the slow movement strobe `moveclk` steps the object's screen position by a velocity (vx, vy) in a direction (dx, dy).
- The result is clamped to the visible 640x480 area.
- Outputs `posx`/`posy` feed the renderer's object-placement logic.

---
 rtl/object_transition_pkg.sv | 14 +
 rtl/object_transition_axis_stepper.sv | 42 ++++
 rtl/object_transition.sv | 58 +++++
 tb/tb_object_transition.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/object_transition_pkg.sv
// Screen geometry and direction encodings shared by the
// object position integrator.
package object_transition_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam int XMAX_DEF = SCREEN_W - 1;
  localparam int YMAX_DEF = SCREEN_H - 1;

  localparam logic DIR_INC = 1'b0;
  localparam logic DIR_DEC = 1'b1;

endpackage

// File: rtl/object_transition_axis_stepper.sv
// One axis of the position integrator: a saturating
// add/subtract register clamped to [0, MAX].
module axis_stepper
  import object_transition_pkg::*;
#(
  parameter int W   = 10,
  parameter int MAX = XMAX_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic [W-1:0] init,
  input  logic [W-1:0] v,
  input  logic         dir,
  output logic [W-1:0] pos
);

  localparam logic [W:0]   MAX_WIDE = (W+1)'(MAX);
  localparam logic [W-1:0] MAX_POS  = W'(MAX);

  logic [W:0]   sum;
  logic [W-1:0] nxt;

  assign sum = {1'b0, pos} + {1'b0, v};

  // One extra bit on the sum keeps the clamp free of wrap.
  always_comb begin
    nxt = pos;
    if (dir == DIR_DEC)
      nxt = (v > pos) ? '0 : pos - v;
    else
      nxt = (sum > MAX_WIDE) ? MAX_POS : sum[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst)
      pos <= init;
    else if (tick)
      pos <= nxt;
  end

endmodule

// File: rtl/object_transition.sv
// Per-object 2D position integrator stepped on each rising
// edge of the movement strobe, clamped to the visible area.
module object_transition
  import object_transition_pkg::*;
#(
  parameter int XMAX = XMAX_DEF,
  parameter int YMAX = YMAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       moveclk,
  input  logic [9:0] initPosX,
  input  logic [8:0] initPosY,
  input  logic [9:0] vx,
  input  logic [8:0] vy,
  input  logic [1:0] dx,
  input  logic [1:0] dy,
  output logic [9:0] posx,
  output logic [8:0] posy
);

  logic mc_q;
  logic tick;

  // Tracking the strobe through reset avoids a step on release.
  always_ff @(posedge clk) begin
    mc_q <= moveclk;
  end

  assign tick = moveclk & ~mc_q;

  axis_stepper #(
    .W   (10),
    .MAX (XMAX)
  ) u_x (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .init (initPosX),
    .v    (vx),
    .dir  (dx[0]),
    .pos  (posx)
  );

  axis_stepper #(
    .W   (9),
    .MAX (YMAX)
  ) u_y (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .init (initPosY),
    .v    (vy),
    .dir  (dy[0]),
    .pos  (posy)
  );

endmodule

// File: tb/tb_object_transition.sv
// Directed-vector bench for object_transition with
// hand-computed expected positions.
module tb_object_transition;

  logic       clk;
  logic       rst;
  logic       moveclk;
  logic [9:0] initPosX;
  logic [8:0] initPosY;
  logic [9:0] vx;
  logic [8:0] vy;
  logic [1:0] dx;
  logic [1:0] dy;
  logic [9:0] posx;
  logic [8:0] posy;

  int n_chk;
  int n_pass;

  object_transition dut (
    .clk      (clk),
    .rst      (rst),
    .moveclk  (moveclk),
    .initPosX (initPosX),
    .initPosY (initPosY),
    .vx       (vx),
    .vy       (vy),
    .dx       (dx),
    .dy       (dy),
    .posx     (posx),
    .posy     (posy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset(input logic [9:0] ix,
                          input logic [8:0] iy);
    initPosX = ix;
    initPosY = iy;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One-cycle strobe pulse; positions are updated at return.
  task automatic pulse();
    moveclk = 1'b1;
    @(negedge clk);
    moveclk = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    moveclk = 1'b0;
    initPosX = 10'd100;
    initPosY = 9'd200;
    vx = '0;
    vy = '0;
    dx = '0;
    dy = '0;
    cycles(2);
    rst = 1'b0;

    check("reset_x", 32'(posx), 32'd100);
    check("reset_y", 32'(posy), 32'd200);
    cycles(50);
    check("hold_x", 32'(posx), 32'd100);
    check("hold_y", 32'(posy), 32'd200);

    // single step, strobe held high 10 cycles
    vx = 10'd5;
    vy = 9'd3;
    dx = 2'b00;
    dy = 2'b01;
    moveclk = 1'b1;
    @(negedge clk);
    check("step_x", 32'(posx), 32'd105);
    check("step_y", 32'(posy), 32'd197);
    cycles(9);
    moveclk = 1'b0;
    cycles(2);
    check("once_x", 32'(posx), 32'd105);
    check("once_y", 32'(posy), 32'd197);

    // saturation high
    do_reset(10'd630, 9'd470);
    vx = 10'd20;
    vy = 9'd50;
    dx = 2'b00;
    dy = 2'b00;
    pulse();
    check("sat_hi_x", 32'(posx), 32'd639);
    check("sat_hi_y", 32'(posy), 32'd479);
    pulse();
    check("sat_hi_x2", 32'(posx), 32'd639);
    check("sat_hi_y2", 32'(posy), 32'd479);

    // saturation low
    do_reset(10'd4, 9'd0);
    vx = 10'd10;
    vy = 9'd1;
    dx = 2'b01;
    dy = 2'b01;
    pulse();
    check("sat_lo_x", 32'(posx), 32'd0);
    check("sat_lo_y", 32'(posy), 32'd0);

    // reserved bit, zero velocity, sampling only on tick
    do_reset(10'd100, 9'd100);
    vx = 10'd7;
    vy = 9'd0;
    dx = 2'b10;
    dy = 2'b00;
    pulse();
    check("rsv_x", 32'(posx), 32'd107);
    check("vy0_y", 32'(posy), 32'd100);
    dx = 2'b00;
    pulse();
    check("norsv_x", 32'(posx), 32'd114);
    vx = 10'd50;
    dx = 2'b01;
    cycles(3);
    check("between_x", 32'(posx), 32'd114);
    vx = 10'd1;
    dx = 2'b00;
    pulse();
    check("next_x", 32'(posx), 32'd115);

    // out-of-range initial value
    do_reset(10'd1000, 9'd500);
    check("oor_load_x", 32'(posx), 32'd1000);
    check("oor_load_y", 32'(posy), 32'd500);
    vx = 10'd1;
    vy = 9'd1;
    dx = 2'b00;
    dy = 2'b00;
    pulse();
    check("oor_inc_x", 32'(posx), 32'd639);
    check("oor_inc_y", 32'(posy), 32'd479);
    do_reset(10'd1000, 9'd500);
    vx = 10'd10;
    vy = 9'd20;
    dx = 2'b01;
    dy = 2'b01;
    pulse();
    check("oor_dec_x", 32'(posx), 32'd990);
    check("oor_dec_y", 32'(posy), 32'd480);

    // reset priority over a coincident strobe rise
    initPosX = 10'd50;
    initPosY = 9'd60;
    vx = 10'd9;
    vy = 9'd2;
    dx = 2'b00;
    dy = 2'b00;
    rst = 1'b1;
    moveclk = 1'b1;
    @(negedge clk);
    check("rstpri_x", 32'(posx), 32'd50);
    check("rstpri_y", 32'(posy), 32'd60);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rel_x", 32'(posx), 32'd50);
    moveclk = 1'b0;
    @(negedge clk);
    pulse();
    check("after_x", 32'(posx), 32'd59);
    check("after_y", 32'(posy), 32'd62);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
